// File: rtl/hermes_vc_pkg.sv
// rtl/hermes_vc_pkg.sv - shared types and width helpers for the Hermes VC input buffer
//
// Purpose: per-VC send FSM encoding and derived-width helpers used by
// hermes_vc_buffer and hermes_vc_fifo.
// Ports: none (package).

package hermes_vc_pkg;

  // One-hot send FSM; any other encoding is treated as illegal and recovers to SEND_INIT.
  typedef enum logic [2:0] {
    SEND_INIT    = 3'b001,
    SEND_REQ     = 3'b010,
    SEND_PAYLOAD = 3'b100
  } fsm_t;

  // VC tag width, never narrower than one bit so a single-VC build still has a port.
  function automatic int vc_width(input int num_vc);
    return (num_vc <= 1) ? 1 : $clog2(num_vc);
  endfunction

  // Occupancy counter width; one extra bit so a completely full FIFO is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hermes_vc_fifo.sv
// rtl/hermes_vc_fifo.sv - single-VC circular first-word-fall-through FIFO with occupancy count
//
// Purpose: one virtual-channel flit queue. The head entry is always presented on
// data_o; it is meaningful only while empty_o is 0.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset (clears pointers/count only)
//   push_i, data_i    write request and entry; ignored while full
//   pop_i             consume the head entry; ignored while empty
//   data_o            head entry (stale storage while empty)
//   count_o           number of stored entries, 0..DEPTH
//   full_o, empty_o   count_o == DEPTH / count_o == 0

module hermes_vc_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 33,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == DEPTH_CNT);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // DEPTH is a power of two, so the pointers wrap naturally at PTR_W bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/hermes_vc_buffer.sv
// rtl/hermes_vc_buffer.sv - multi-VC input buffer for one Hermes router input port
//
// Purpose: steers incoming flits by VC tag into NUM_VC independent FWFT FIFOs,
// runs a per-VC request/payload FSM toward switch control and crossbar, and
// reports per-VC occupancy plus sticky overflow / illegal-VC flags.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   rx_i, vc_i, eop_i,     incoming flit valid, VC tag, end-of-packet, payload
//   data_i
//   credit_o[v]            VC v has room for another flit
//   data_av_o[v]           VC v head flit is valid toward the crossbar (payload phase only)
//   eop_o[v], data_o       VC v head flit EOP bit and payload (slice v*FLIT_SIZE)
//   data_ack_i[v]          VC v head flit consumed (ignored while empty)
//   req_o[v], req_ack_i[v] routing request / grant handshake for VC v
//   sending_o[v]           VC v is in its payload phase
//   occupancy_o            per-VC flit count (slice v*CNT_W)
//   overflow_o[v]          sticky: flit arrived for VC v without credit
//   bad_vc_o               sticky: flit arrived with vc_i >= NUM_VC

module hermes_vc_buffer
  import hermes_vc_pkg::*;
#(
  parameter  int NUM_VC      = 2,
  parameter  int BUFFER_SIZE = 8,
  parameter  int FLIT_SIZE   = 32,
  localparam int VC_W        = vc_width(NUM_VC),
  localparam int CNT_W       = cnt_width(BUFFER_SIZE)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        rx_i,
  input  logic [VC_W-1:0]             vc_i,
  input  logic                        eop_i,
  input  logic [FLIT_SIZE-1:0]        data_i,
  output logic [NUM_VC-1:0]           credit_o,
  output logic [NUM_VC-1:0]           data_av_o,
  output logic [NUM_VC-1:0]           eop_o,
  input  logic [NUM_VC-1:0]           data_ack_i,
  output logic [NUM_VC*FLIT_SIZE-1:0] data_o,
  output logic [NUM_VC-1:0]           req_o,
  input  logic [NUM_VC-1:0]           req_ack_i,
  output logic [NUM_VC-1:0]           sending_o,
  output logic [NUM_VC*CNT_W-1:0]     occupancy_o,
  output logic [NUM_VC-1:0]           overflow_o,
  output logic                        bad_vc_o
);

  // One extra bit on the compare so a tag equal to NUM_VC (e.g. 3 with 3 VCs) is caught.
  localparam logic [VC_W:0] NUM_VC_L = (VC_W+1)'(NUM_VC);

  logic vc_legal;
  logic bad_vc_q, bad_vc_d;

  assign vc_legal = ({1'b0, vc_i} < NUM_VC_L);

  always_comb begin
    bad_vc_d = bad_vc_q | (rx_i & ~vc_legal);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) bad_vc_q <= 1'b0;
    else         bad_vc_q <= bad_vc_d;
  end

  assign bad_vc_o = bad_vc_q;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic               hit;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [FLIT_SIZE:0] head;
    logic [CNT_W-1:0]   count;
    fsm_t               state_q, state_d;
    logic               overflow_q, overflow_d;

    assign hit  = rx_i & vc_legal & (vc_i == VC_W'(v));
    assign push = hit & ~full;
    // Pop follows the ack regardless of FSM phase; an empty FIFO ignores it.
    assign pop  = data_ack_i[v] & ~empty;

    hermes_vc_fifo #(
      .DEPTH (BUFFER_SIZE),
      .WIDTH (FLIT_SIZE + 1)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  ({eop_i, data_i}),
      .data_o  (head),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
    );

    always_comb begin
      state_d    = state_q;
      overflow_d = overflow_q | (hit & full);
      case (state_q)
        SEND_INIT:    if (!empty)         state_d = SEND_REQ;
        SEND_REQ:     if (req_ack_i[v])   state_d = SEND_PAYLOAD;
        // Packet ends only when the EOP head flit is actually consumed.
        SEND_PAYLOAD: if (pop && head[FLIT_SIZE]) state_d = SEND_INIT;
        default:      state_d = SEND_INIT;
      endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q    <= SEND_INIT;
        overflow_q <= 1'b0;
      end else begin
        state_q    <= state_d;
        overflow_q <= overflow_d;
      end
    end

    assign credit_o[v]                           = ~full;
    assign req_o[v]                              = (state_q == SEND_REQ);
    assign sending_o[v]                          = (state_q == SEND_PAYLOAD);
    assign data_av_o[v]                          = (state_q == SEND_PAYLOAD) & ~empty;
    assign eop_o[v]                              = head[FLIT_SIZE];
    assign data_o[v*FLIT_SIZE +: FLIT_SIZE]      = head[FLIT_SIZE-1:0];
    assign occupancy_o[v*CNT_W +: CNT_W]         = count;
    assign overflow_o[v]                         = overflow_q;
  end

endmodule

// File: tb/tb_hermes_vc_buffer.sv
// tb/tb_hermes_vc_buffer.sv - self-checking bench for hermes_vc_buffer (3 VCs, depth 8)

module tb_hermes_vc_buffer;

  localparam int NV    = 3;
  localparam int DEPTH = 8;
  localparam int FW    = 32;
  localparam int CW    = 4;

  logic          clk;
  logic          rst_n;
  logic          rx;
  logic [1:0]    vc;
  logic          eop;
  logic [FW-1:0] data;
  logic [NV-1:0] credit, data_av, eop_o, ack, req, rack, sending, ovf;
  logic [NV*FW-1:0] dout;
  logic [NV*CW-1:0] occ;
  logic          bad;

  int checks = 0;
  int errors = 0;

  hermes_vc_buffer #(
    .NUM_VC      (NV),
    .BUFFER_SIZE (DEPTH),
    .FLIT_SIZE   (FW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rx_i        (rx),
    .vc_i        (vc),
    .eop_i       (eop),
    .data_i      (data),
    .credit_o    (credit),
    .data_av_o   (data_av),
    .eop_o       (eop_o),
    .data_ack_i  (ack),
    .data_o      (dout),
    .req_o       (req),
    .req_ack_i   (rack),
    .sending_o   (sending),
    .occupancy_o (occ),
    .overflow_o  (ovf),
    .bad_vc_o    (bad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-VC queue of {eop,data}, packet phase (0 idle, 1 request, 2 payload).
  logic [FW:0] mq [NV][$];
  int          ph [NV];
  bit          m_ovf [NV];
  bit          m_bad;

  always @(posedge clk or negedge rst_n) begin
    int n;
    bit hd_eop, do_pop, do_push;
    if (!rst_n) begin
      for (int v = 0; v < NV; v++) begin
        mq[v].delete();
        ph[v]    = 0;
        m_ovf[v] = 1'b0;
      end
      m_bad = 1'b0;
    end else begin
      for (int v = 0; v < NV; v++) begin
        n       = mq[v].size();
        hd_eop  = (n > 0) ? mq[v][0][FW] : 1'b0;
        do_pop  = ack[v] && (n > 0);
        do_push = rx && (int'(vc) == v) && (n < DEPTH);
        if (ph[v] == 0 && n > 0)               ph[v] = 1;
        else if (ph[v] == 1 && rack[v])        ph[v] = 2;
        else if (ph[v] == 2 && do_pop && hd_eop) ph[v] = 0;
        if (rx && int'(vc) == v && n == DEPTH) m_ovf[v] = 1'b1;
        if (do_pop)  void'(mq[v].pop_front());
        if (do_push) mq[v].push_back({eop, data});
      end
      if (rx && int'(vc) >= NV) m_bad = 1'b1;
    end
  end

  // Outputs depend only on registered state, so checking at the falling edge is stable.
  always @(negedge clk) begin
    for (int v = 0; v < NV; v++) begin
      chk($sformatf("credit%0d", v),  credit[v],          (mq[v].size() < DEPTH));
      chk($sformatf("occ%0d", v),     occ[v*CW +: CW],    mq[v].size());
      chk($sformatf("req%0d", v),     req[v],             (ph[v] == 1));
      chk($sformatf("sending%0d", v), sending[v],         (ph[v] == 2));
      chk($sformatf("data_av%0d", v), data_av[v],         (ph[v] == 2) && (mq[v].size() > 0));
      chk($sformatf("ovf%0d", v),     ovf[v],             m_ovf[v]);
      if (mq[v].size() > 0)
        chk($sformatf("head%0d", v), {eop_o[v], dout[v*FW +: FW]}, mq[v][0]);
    end
    chk("bad_vc", bad, m_bad);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] v, input logic e, input logic [31:0] d);
    rx = 1'b1; vc = v; eop = e; data = d;
    @(negedge clk);
    rx = 1'b0;
  endtask

  int pulses;
  bit prev_req, prev_send;

  initial begin
    rst_n = 1'b0; rx = 1'b0; vc = '0; eop = 1'b0; data = '0; ack = '0; rack = '0;
    repeat (2) cyc();
    chk("rst_credit", credit, 3'b111);
    chk("rst_req", {req, sending, data_av}, 9'b0);
    chk("rst_occ", occ, 12'b0);
    chk("rst_flags", {ovf, bad}, 4'b0);
    rst_n = 1'b1;

    // 3-flit packet on VC0
    send(0, 1'b0, 32'hA1);
    send(0, 1'b0, 32'hA2);
    chk("t1_req", req, 3'b001);
    send(0, 1'b1, 32'hA3);
    chk("t1_req_hold", {req, sending}, 6'b001_000);
    rack[0] = 1'b1; cyc(); rack[0] = 1'b0;
    chk("t1_sending", sending, 3'b001);
    chk("t1_flit0", dout[31:0], 32'hA1);
    ack[0] = 1'b1; cyc();
    chk("t1_flit1", dout[31:0], 32'hA2);
    cyc();
    chk("t1_flit2", {eop_o[0], dout[31:0]}, 33'h1_0000_00A3);
    cyc(); ack[0] = 1'b0;
    chk("t1_idle", {req, sending}, 6'b0);
    chk("t1_occ0", occ[3:0], 4'd0);

    // Fill VC1, then overflow it
    for (int i = 0; i < 8; i++) send(1, (i == 7), 32'h100 + i);
    chk("t2_occ_full", occ[7:4], 4'd8);
    chk("t2_credit", credit, 3'b101);
    send(1, 1'b0, 32'h1FF);
    chk("t2_ovf", ovf, 3'b010);
    chk("t2_occ_still8", occ[7:4], 4'd8);
    chk("t2_vc0_quiet", occ[3:0], 4'd0);
    rack[1] = 1'b1; cyc(); rack[1] = 1'b0;
    ack[1] = 1'b1; repeat (8) cyc(); ack[1] = 1'b0;
    chk("t2_drained", {occ[7:4], sending[1]}, 5'b0);
    chk("t2_ovf_sticky", ovf, 3'b010);

    // Interleaved packets on VC0 and VC1
    for (int i = 0; i < 4; i++) begin
      send(0, (i == 3), 32'h10 + i);
      send(1, (i == 3), 32'h20 + i);
    end
    rack = 3'b011; cyc(); rack = '0;
    chk("t3_heads", {dout[63:32], dout[31:0]}, {32'h20, 32'h10});
    chk("t3_av", data_av, 3'b011);
    ack = 3'b011; repeat (4) cyc(); ack = '0;
    chk("t3_done", {occ, sending}, 15'b0);

    // Streaming with ack held: 20 flits wrap the pointers
    ack[0] = 1'b1; rack[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(0, (i == 19), 32'h300 + i);
      chk("t4_occ_le1", occ[3:0], 4'd1);
    end
    repeat (3) cyc();
    ack[0] = 1'b0; rack[0] = 1'b0;
    chk("t4_done", {occ[3:0], sending[0]}, 5'b0);

    // Back-to-back packets on VC0
    send(0, 1'b0, 32'hB0);
    send(0, 1'b1, 32'hB1);
    send(0, 1'b0, 32'hC0);
    send(0, 1'b1, 32'hC1);
    pulses = 0; prev_req = 1'b0; prev_send = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (req[0] && !prev_req) pulses++;
      if (prev_send && !sending[0]) chk("t5_init_gap", req[0], 1'b0);
      prev_req  = req[0];
      prev_send = sending[0];
      rack[0] = req[0];
      ack[0]  = sending[0];
      cyc();
    end
    ack = '0; rack = '0;
    chk("t5_req_pulses", pulses, 2);
    chk("t5_occ", occ[3:0], 4'd0);

    // Illegal VC tag, then reset mid-packet
    send(3, 1'b0, 32'hDEAD);
    chk("t6_bad", bad, 1'b1);
    chk("t6_no_write", occ, 12'b0);
    send(2, 1'b0, 32'h31);
    send(2, 1'b0, 32'h32);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_credit", credit, 3'b111);
    chk("t6_rst_occ", occ, 12'b0);
    chk("t6_rst_flags", {ovf, bad, req, sending}, 10'b0);
    cyc();
    rst_n = 1'b1;
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/hermes_vc_buffer.md
Name: hermes_vc_buffer

Overview:
- Multi-virtual-channel input buffer for one Hermes router input port.
- Demultiplexes incoming flits by VC tag into NUM_VC independent circular FIFOs with per-VC credit.
- Each VC runs its own routing-request/payload FSM toward the switch control and crossbar.
- Adds per-VC occupancy reporting and sticky overflow/illegal-VC error flags.

Parameters:
- NUM_VC, 2, number of virtual channels (1..8).
- BUFFER_SIZE, 8, flits per VC FIFO; power of 2, >= 2.
- FLIT_SIZE, 32, flit data width; minimum 20.
- VC_W, $clog2(NUM_VC) (min 1), derived width of VC tag; not user-set.
- CNT_W, $clog2(BUFFER_SIZE)+1, derived occupancy counter width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- rx_i  in  1  flit valid on input link
- vc_i  in  VC_W  VC tag of incoming flit
- eop_i  in  1  incoming flit is end of packet
- data_i  in  FLIT_SIZE  incoming flit
- credit_o  out  NUM_VC  per-VC space available
- data_av_o  out  NUM_VC  per-VC flit valid toward crossbar
- eop_o  out  NUM_VC  per-VC head flit is EOP
- data_ack_i  in  NUM_VC  per-VC flit consumed
- data_o  out  NUM_VC*FLIT_SIZE  per-VC head flit, VC v at bits [v*FLIT_SIZE +: FLIT_SIZE]
- req_o  out  NUM_VC  per-VC routing request
- req_ack_i  in  NUM_VC  per-VC routing granted
- sending_o  out  NUM_VC  per-VC payload phase active
- occupancy_o  out  NUM_VC*CNT_W  per-VC flit count
- overflow_o  out  NUM_VC  sticky: flit arrived for a VC with no credit
- bad_vc_o  out  1  sticky: flit arrived with vc_i >= NUM_VC

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clk_i is the clock.
  - Reset clears all FIFO pointers and counts to 0, all FSMs to SEND_INIT, and the sticky flags.
  - Outputs during and after reset: credit_o all 1, data_av_o/req_o/sending_o/overflow_o/bad_vc_o all 0, occupancy_o all 0.
  - data_o and eop_o reflect stale storage and are don't-care while data_av_o is 0.
- Write: on a clk edge with rx_i=1, vc_i=v<NUM_VC and credit_o[v]=1, store {eop_i,data_i} at wr_ptr[v] and increment wr_ptr[v] modulo BUFFER_SIZE.
- credit_o[v] = (count[v] < BUFFER_SIZE), combinational from the registered count.
- Drop cases:
  - rx_i=1 with credit_o[v]=0: flit dropped, overflow_o[v] set next cycle.
  - rx_i=1 with vc_i>=NUM_VC: flit dropped, bad_vc_o set next cycle.
  - Both flags hold until reset.
- Read side: first-word fall-through. Head flit is visible on data_o[v]/eop_o[v] whenever count[v]>0.
  - Pop on an edge where data_ack_i[v]=1 and count[v]>0; rd_ptr increments modulo BUFFER_SIZE.
- Latency: a flit written at edge t is at the head and visible at t+1 (empty FIFO). data_av_o rises at t+1 only if the FSM is already in SEND_PAYLOAD.
- Count: simultaneous push and pop on the same VC leaves count unchanged. Push-only increments, pop-only decrements.
  - A full FIFO cannot push (no credit).
  - An empty FIFO cannot pop: ack is ignored when count=0.
  - Pointers wrap from BUFFER_SIZE-1 to 0.
- Per-VC FSM, one-hot: SEND_INIT=001, SEND_REQ=010, SEND_PAYLOAD=100.
  - SEND_INIT -> SEND_REQ when count[v]>0.
  - SEND_REQ -> SEND_PAYLOAD when req_ack_i[v].
  - SEND_PAYLOAD -> SEND_INIT when data_ack_i[v] & count[v]>0 & head eop.
  - An illegal encoding returns to SEND_INIT.
  - req_o[v] = (state==SEND_REQ).
  - sending_o[v] = (state==SEND_PAYLOAD).
  - data_av_o[v] = sending_o[v] & (count[v]>0).
- VCs are fully independent. Activity on VC a never alters pointers, state or flags of VC b≠a.
- Back-to-back packets: after EOP is consumed the FSM spends ≥1 cycle in SEND_INIT, then requests again if the FIFO is non-empty.
- Reset mid-packet discards all buffered flits. There is no partial-packet recovery.
- occupancy_o[v] = count[v], range 0..BUFFER_SIZE.

Decomposition:
- Package hermes_vc_pkg holds:
  - fsm_t enum (3-bit one-hot, as above).
  - A helper function for VC_W/CNT_W.
- Sub-module hermes_vc_fifo: a single circular FWFT FIFO with count, push/pop, full/empty. It is instantiated NUM_VC times in a generate loop. The FSM and flags stay in the top module.

Test Plan:
- Reset, then send a 3-flit packet on VC0 (0xA1, 0xA2, 0xA3 with eop):
  - req_o=01 one cycle after the first write.
  - Assert req_ack_i[0] -> sending_o[0]=1.
  - Ack each flit -> data_o VC0 shows A1, A2, A3 in order.
  - FSM returns to SEND_INIT after the A3 ack.
  - VC1 outputs stay idle throughout.
- NUM_VC=2, BUFFER_SIZE=8: write 8 flits to VC1 with no ack -> occupancy_o[VC1]=8, credit_o=01. A 9th write -> dropped, overflow_o[1]=1 sticky, VC0 unaffected.
- Interleave flits VC0/VC1 every cycle, two packets of 4 flits each (0x10.., 0x20..), and grant both -> each VC delivers its own packet intact and in order.
- Hold data_ack_i[0]=1 continuously while pushing 1 flit/cycle to VC0 -> occupancy stays ≤1 and throughput is 1 flit/cycle after the request phase. Wrap past pointer 7->0 over 20 flits with no loss.
- Back-to-back packets queued on VC0 (2 flits + 2 flits) -> two separate req_o pulses, with ≥1 idle SEND_INIT cycle between EOP ack and the second request.
- Drive vc_i=3 with NUM_VC=3 -> bad_vc_o=1, no FIFO changes. Then assert rst_ni=0 mid-packet -> all counts 0, credit_o=111, flags cleared.
